// File: rtl/boot_pkg.sv
// Shared state encoding, stream constants and checksum helper for the boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        CSUM  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } boot_state_t;

    localparam int unsigned BOOT_LEN_BYTES  = 4;
    localparam int unsigned BOOT_WORD_BYTES = 4;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid_o fires
// combinationally with the 4th byte so the caller can register the write.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    // New bytes enter at the top and shift right, so the first byte lands in [7:0].
    always_comb begin
        word_o       = {byte_data_i, acc_q[31:8]};
        word_valid_o = byte_valid_i && (cnt_q == 2'(BOOT_WORD_BYTES - 1));
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = word_o;
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end
    end

    // Byte counter and assembly register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            acc_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: length header, word writes to instruction memory,
// core held in reset until done. Define BOOT_CHECKSUM_EN for the trailing XOR byte.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  mem_w_enb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W     = ADDR_BITS - 1;
    localparam logic [31:0] CAP_WORDS = 32'(1) << (ADDR_BITS - 2);

    boot_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic             in_ready_q;
    logic [3:0]       mem_w_enb_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_w_data_q;
    logic             core_rst_q;
    logic             done_q;
    logic             error_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic        fire_s;
    logic        pack_valid_s;
    logic        word_valid_s;
    logic [31:0] word_s;
    logic        wr_s;

    assign fire_s       = in_valid && in_ready_q;
    assign pack_valid_s = fire_s && ((state_q == LEN) || (state_q == DATA));
    assign wr_s         = word_valid_s && (state_q == DATA);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (pack_valid_s),
        .byte_data_i  (in_data),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // Next-state decode: length check, word counting and checksum compare.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            LEN: begin
                if (word_valid_s) begin
                    len_d = word_s[IDX_W-1:0];
                    if (word_s > CAP_WORDS) begin
                        state_d = ERROR;
                    end else if (word_s == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = LEN;
                end
            end
            DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (fire_s) begin
                    csum_d = csum_update(csum_q, in_data);
                end else begin
                    csum_d = csum_q;
                end
`endif
                if (word_valid_s) begin
                    idx_d = idx_q + IDX_W'(1);
                    if ((idx_q + IDX_W'(1)) == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (fire_s) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end else begin
                    state_d = CSUM;
                end
            end
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LEN;
            idx_q        <= {IDX_W{1'b0}};
            len_q        <= {IDX_W{1'b0}};
            in_ready_q   <= 1'b0;
            mem_w_enb_q  <= 4'h0;
            mem_addr_q   <= 32'd0;
            mem_w_data_q <= 32'd0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            in_ready_q  <= (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
            mem_w_enb_q <= wr_s ? 4'hF : 4'h0;
            if (wr_s) begin
                mem_addr_q   <= 32'({idx_q, 2'b00});
                mem_w_data_q <= word_s;
            end
            core_rst_q  <= (state_d != DONE);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERROR);
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_w_enb  = mem_w_enb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: reset values, table of randomized loads
// checked against a stream model, and hand sequences for the timing corners.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  mem_w_enb;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        core_rst;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_BITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_w_enb  (mem_w_enb),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int enb_odd = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc++;

    // Write monitor: record every memory write pulse and any illegal enable pattern.
    always @(negedge clk) begin
        if (mem_w_enb == 4'hF) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_w_data);
            wr_cyc.push_back(cyc);
        end else if (mem_w_enb != 4'h0) begin
            enb_odd++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        enb_odd = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted; returns just after the accepting edge.
    task automatic push(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) push(8'(w >> (8 * i)));
    endtask

    typedef struct {
        logic [31:0] len;
        bit          gaps;
        bit          exp_err;
        int          exp_nw;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd0,          1'b0, 1'b0, 0};
        vecs[1] = '{32'd1,          1'b1, 1'b0, 1};
        vecs[2] = '{32'd3,          1'b0, 1'b0, 3};
        vecs[3] = '{32'd7,          1'b1, 1'b0, 7};
        vecs[4] = '{32'd256,        1'b0, 1'b0, 256};
        vecs[5] = '{32'd257,        1'b1, 1'b1, 0};
        vecs[6] = '{32'h8000_0000,  1'b0, 1'b1, 0};
        vecs[7] = '{32'h0001_0001,  1'b1, 1'b1, 0};

        // Reset values.
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_enb",        32'(mem_w_enb),  32'd0);
        chk("rst_addr",       mem_addr,        32'd0);
        chk("rst_data",       mem_w_data,      32'd0);
        chk("rst_core_rst",   32'(core_rst),   32'd1);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_error",      32'(error),      32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Two-word image back to back.
        do_reset();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        @(negedge clk);
        chk("seq1_enb2",  32'(mem_w_enb), 32'hF);
        chk("seq1_addr2", mem_addr,       32'd4);
        chk("seq1_data2", mem_w_data,     32'h0010_0093);
`ifdef BOOT_CHECKSUM_EN
        chk("seq1_done_pre", 32'(done), 32'd0);
        push(8'h90);
        @(negedge clk);
`endif
        chk("seq1_done",     32'(done),     32'd1);
        chk("seq1_core_rst", 32'(core_rst), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("seq1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("seq1_addr1", wr_addr[0], 32'd0);
            chk("seq1_data1", wr_data[0], 32'h0000_0013);
            chk("seq1_gap",   32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        end

`ifdef BOOT_CHECKSUM_EN
        // Checksum good and bad.
        do_reset();
        push_word(32'd1);
        push_word(32'hDEAD_BEEF);
        push(8'h22);
        @(negedge clk);
        chk("csum_ok_done", 32'(done), 32'd1);
        chk("csum_ok_wr",   wr_data.size() > 0 ? wr_data[0] : 32'hX, 32'hDEAD_BEEF);
        do_reset();
        push_word(32'd1);
        push_word(32'hDEAD_BEEF);
        push(8'h23);
        @(negedge clk);
        chk("csum_bad_err",  32'(error),    32'd1);
        chk("csum_bad_crst", 32'(core_rst), 32'd1);
        chk("csum_bad_done", 32'(done),     32'd0);
`endif

        // Oversized length.
        do_reset();
        push_word(32'h0000_0101);
        @(negedge clk);
        chk("big_err",      32'(error),    32'd1);
        chk("big_core_rst", 32'(core_rst), 32'd1);
        chk("big_in_ready", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("big_nwr", 32'(wr_addr.size()), 32'd0);

        // Gappy valid: 1,0,0,1,...
        do_reset();
        begin
            logic [31:0] w;
            w = 32'hA5C3_1E77;
            for (int i = 0; i < 8; i++) begin
                push(i < 4 ? 8'(32'd1 >> (8 * i)) : 8'(w >> (8 * (i - 4))));
                if (i == 6) begin
                    @(negedge clk);
                    chk("gap_nowr_early", 32'(wr_addr.size()), 32'd0);
                    #1;
                end
                if (i < 7) idle(2);
            end
            @(negedge clk);
            chk("gap_enb",  32'(mem_w_enb), 32'hF);
            chk("gap_addr", mem_addr,       32'd0);
            chk("gap_data", mem_w_data,     w);
        end

        // Reset in the middle of a load, then a fresh image.
        do_reset();
        push_word(32'd2);
        push(8'hAA);
        push(8'hBB);
        do_reset();
        push_word(32'd1);
        push_word(32'h1122_3344);
        @(negedge clk);
        chk("mid_addr", mem_addr,   32'd0);
        chk("mid_data", mem_w_data, 32'h1122_3344);
`ifdef BOOT_CHECKSUM_EN
        push(8'h44);
        @(negedge clk);
`endif
        chk("mid_done", 32'(done), 32'd1);

        // Traffic after done is ignored.
        #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("post_in_ready", 32'(in_ready), 32'd0);
            chk("post_done",     32'(done),     32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_nwr", 32'(wr_addr.size()), 32'd1);

        // Table-driven randomized loads against the stream model.
        for (int v = 0; v < 8; v++) begin
            logic [31:0] words[$];
            logic [7:0]  sum;
            words.delete();
            sum = 8'h00;
            for (int i = 0; i < vecs[v].exp_nw; i++) words.push_back($urandom);
            do_reset();
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
                push(8'(vecs[v].len >> (8 * i)));
            end
            if (!vecs[v].exp_err) begin
                for (int k = 0; k < words.size(); k++) begin
                    for (int i = 0; i < 4; i++) begin
                        if (vecs[v].gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
                        push(8'(words[k] >> (8 * i)));
                        sum = sum ^ 8'(words[k] >> (8 * i));
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                push(sum);
`endif
            end
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("tbl%0d_done", v),     32'(done),     32'(!vecs[v].exp_err));
            chk($sformatf("tbl%0d_error", v),    32'(error),    32'(vecs[v].exp_err));
            chk($sformatf("tbl%0d_core_rst", v), 32'(core_rst), 32'(vecs[v].exp_err));
            chk($sformatf("tbl%0d_in_ready", v), 32'(in_ready), 32'd0);
            chk($sformatf("tbl%0d_nwr", v),      32'(wr_addr.size()), 32'(vecs[v].exp_nw));
            chk($sformatf("tbl%0d_enb_odd", v),  32'(enb_odd),  32'd0);
            for (int k = 0; k < words.size(); k++) begin
                if (k < wr_addr.size()) begin
                    chk($sformatf("tbl%0d_addr%0d", v, k), wr_addr[k], 32'(4 * k));
                    chk($sformatf("tbl%0d_data%0d", v, k), wr_data[k], words[k]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
